// File: rtl/ec_mul_arbiter.sv
// Round-robin arbiter sharing one scalar-multiplication engine between NREQ requesters.
// Captures the winner's operands, pulses the engine start, waits for the engine finish
// pulse and returns the result with a per-requester done pulse. Zero scalars complete
// locally with the point at infinity (all-ones) and never start the engine.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req                    per-requester request level (sampled only while idle)
//   i_x, i_y, i_n            per-requester point/scalar, slice k = [256k+255:256k]
//   o_gnt, o_done            one-hot single-cycle grant / result-valid pulses
//   o_result_x/y, o_cycles   result and engine cycle count, updated with o_done
//   o_busy                   high from grant cycle through done cycle
//   o_eng_start              single-cycle engine start
//   o_eng_x1/y1/n            engine operands, stable for the whole job
//   i_eng_finished           engine finish pulse, i_eng_result_x/y valid with it
module ec_mul_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*256-1:0] i_x,
  input  logic [NREQ*256-1:0] i_y,
  input  logic [NREQ*256-1:0] i_n,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_done,
  output logic [255:0]        o_result_x,
  output logic [255:0]        o_result_y,
  output logic [31:0]         o_cycles,
  output logic                o_busy,
  output logic                o_eng_start,
  output logic [255:0]        o_eng_x1,
  output logic [255:0]        o_eng_y1,
  output logic [255:0]        o_eng_n,
  input  logic                i_eng_finished,
  input  logic [255:0]        i_eng_result_x,
  input  logic [255:0]        i_eng_result_y
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StZero} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [255:0]      res_x_q, res_x_d;
  logic [255:0]      res_y_q, res_y_d;
  logic [255:0]      eng_x_q, eng_x_d;
  logic [255:0]      eng_y_q, eng_y_d;
  logic [255:0]      eng_n_q, eng_n_d;

  logic [255:0]      x_arr [NREQ];
  logic [255:0]      y_arr [NREQ];
  logic [255:0]      n_arr [NREQ];

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   try_idx;

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign x_arr[k] = i_x[256*k +: 256];
    assign y_arr[k] = i_y[256*k +: 256];
    assign n_arr[k] = i_n[256*k +: 256];
  end

  // Round-robin: first set request scanning upward from the last winner + 1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    try_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      try_idx = IdxW'((32'(ptr_q) + i) % NREQ);
      if (!win_found && i_req[try_idx]) begin
        win_found = 1'b1;
        win_idx   = try_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    done_d   = '0;
    start_d  = 1'b0;
    busy_d   = 1'b0;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    eng_x_d  = eng_x_q;
    eng_y_d  = eng_y_q;
    eng_n_d  = eng_n_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          ptr_d   = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          eng_x_d = x_arr[win_idx];
          eng_y_d = y_arr[win_idx];
          eng_n_d = n_arr[win_idx];
          if (n_arr[win_idx] == '0) begin
            state_d = StZero;
          end else begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        busy_d = 1'b1;
        cnt_d  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        if (i_eng_finished) begin
          // Count of full cycles from the start pulse to the finish pulse.
          cycles_d = cnt_q;
          res_x_d  = i_eng_result_x;
          res_y_d  = i_eng_result_y;
          done_d   = NREQ'(1) << ptr_q;
          state_d  = StIdle;
        end
      end
      StZero: begin
        busy_d   = 1'b1;
        cycles_d = '0;
        res_x_d  = {256{1'b1}};
        res_y_d  = {256{1'b1}};
        done_d   = NREQ'(1) << ptr_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= IdxW'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      cycles_q <= '0;
      res_x_q  <= {256{1'b1}};
      res_y_q  <= {256{1'b1}};
      eng_x_q  <= '0;
      eng_y_q  <= '0;
      eng_n_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
      eng_x_q  <= eng_x_d;
      eng_y_q  <= eng_y_d;
      eng_n_q  <= eng_n_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_eng_start = start_q;
  assign o_busy      = busy_q;
  assign o_cycles    = cycles_q;
  assign o_result_x  = res_x_q;
  assign o_result_y  = res_y_q;
  assign o_eng_x1    = eng_x_q;
  assign o_eng_y1    = eng_y_q;
  assign o_eng_n     = eng_n_q;

endmodule

// File: tb/tb_ec_mul_arbiter.sv
// Testbench for ec_mul_arbiter: behavioural engine model, scoreboard of expected jobs,
// a table of single-request vectors and hand-written multi-cycle sequences.
module tb_ec_mul_arbiter;
  localparam int unsigned NREQ = 2;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic [NREQ-1:0]     i_req;
  logic [NREQ*256-1:0] i_x, i_y, i_n;
  logic [NREQ-1:0]     o_gnt, o_done;
  logic [255:0]        o_result_x, o_result_y;
  logic [31:0]         o_cycles;
  logic                o_busy, o_eng_start;
  logic [255:0]        o_eng_x1, o_eng_y1, o_eng_n;
  logic                i_eng_finished;
  logic [255:0]        i_eng_result_x, i_eng_result_y;

  always #5 i_clk = ~i_clk;

  ec_mul_arbiter #(.NREQ(NREQ)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req          (i_req),
    .i_x            (i_x),
    .i_y            (i_y),
    .i_n            (i_n),
    .o_gnt          (o_gnt),
    .o_done         (o_done),
    .o_result_x     (o_result_x),
    .o_result_y     (o_result_y),
    .o_cycles       (o_cycles),
    .o_busy         (o_busy),
    .o_eng_start    (o_eng_start),
    .o_eng_x1       (o_eng_x1),
    .o_eng_y1       (o_eng_y1),
    .o_eng_n        (o_eng_n),
    .i_eng_finished (i_eng_finished),
    .i_eng_result_x (i_eng_result_x),
    .i_eng_result_y (i_eng_result_y)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [255:0]    x;
    logic [255:0]    n;
    logic [255:0]    rx;
    logic [255:0]    ry;
    logic [31:0]     cyc;
  } exp_t;

  typedef struct {
    int           k;
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] n;
    int           lat;
    logic [255:0] rx;
    logic [255:0] ry;
    logic [31:0]  cyc;
  } vec_t;

  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] ONES = {256{1'b1}};

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           step_no = 0;
  int           done_step = 0;
  int           done_cnt = 0;
  int           start_cnt = 0;
  int           gnt_seen = 0;
  int           gnt_limit = 0;
  bit           rel_on_gnt = 1'b0;
  int           eng_cnt = 0;
  int           eng_lat = 1;
  bit           eng_hold = 1'b0;
  logic [255:0] ex_x, ex_y, ex_n;
  logic [255:0] x_v [NREQ];
  logic [255:0] y_v [NREQ];
  logic [255:0] n_v [NREQ];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [255:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want nothing pending", nm, act);
  endtask

  task automatic set_ops(input int k, input logic [255:0] x, input logic [255:0] y,
                         input logic [255:0] n);
    x_v[k[0]] = x;
    y_v[k[0]] = y;
    n_v[k[0]] = n;
    if (k == 0) begin
      i_x[255:0] = x;
      i_y[255:0] = y;
      i_n[255:0] = n;
    end else begin
      i_x[511:256] = x;
      i_y[511:256] = y;
      i_n[511:256] = n;
    end
  endtask

  // Engine model: result = (x ^ (n-1), y + (n-1)); finishes lat cycles after start.
  function automatic exp_t mk_exp(input int k, input int lat);
    exp_t e;
    e.gnt = NREQ'(1 << k);
    e.x   = x_v[k[0]];
    e.n   = n_v[k[0]];
    if (n_v[k[0]] == '0) begin
      e.rx  = ONES;
      e.ry  = ONES;
      e.cyc = '0;
    end else begin
      e.rx  = x_v[k[0]] ^ (n_v[k[0]] - 256'd1);
      e.ry  = y_v[k[0]] + (n_v[k[0]] - 256'd1);
      e.cyc = 32'(lat);
    end
    return e;
  endfunction

  // One clock: sample outputs at the falling edge, check, then advance the engine model.
  task automatic step();
    exp_t e;
    @(negedge i_clk);
    step_no++;
    if (o_eng_start) start_cnt++;
    if (o_gnt != '0) begin
      if (sb.size() == 0) begin
        unexpected("gnt_unexpected", 256'(o_gnt));
      end else begin
        chk("gnt", 256'(o_gnt), 256'(sb[0].gnt));
        chk("eng_x1", o_eng_x1, sb[0].x);
        chk("eng_n", o_eng_n, sb[0].n);
      end
      gnt_seen++;
      if (rel_on_gnt) i_req = i_req & ~o_gnt;
      if (gnt_limit != 0 && gnt_seen >= gnt_limit) i_req = '0;
    end
    if (o_done != '0) begin
      done_step = step_no;
      done_cnt++;
      if (sb.size() == 0) begin
        unexpected("done_unexpected", 256'(o_done));
      end else begin
        e = sb.pop_front();
        chk("done", 256'(o_done), 256'(e.gnt));
        chk("result_x", o_result_x, e.rx);
        chk("result_y", o_result_y, e.ry);
        chk("cycles", 256'(o_cycles), 256'(e.cyc));
        chk("busy_at_done", 256'(o_busy), 256'd1);
      end
    end
    if (i_eng_finished) i_eng_finished = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0 && !eng_hold) begin
        i_eng_finished = 1'b1;
        i_eng_result_x = ex_x ^ (ex_n - 256'd1);
        i_eng_result_y = ex_y + (ex_n - 256'd1);
      end
    end
    if (o_eng_start) begin
      eng_cnt = eng_lat;
      ex_x    = o_eng_x1;
      ex_y    = o_eng_y1;
      ex_n    = o_eng_n;
    end
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while ((sb.size() != 0 || o_busy) && i < max) begin
      step();
      i++;
    end
    if (sb.size() != 0 || o_busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: %0d jobs outstanding busy=%0b after %0d cycles, want 0 and idle",
               sb.size(), o_busy, max);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [4];
    exp_t e;
    int   req_step;
    int   s0;
    int   d0;

    tv[0] = '{k: 0, x: GX, y: GY, n: 256'd1, lat: 5, rx: GX, ry: GY, cyc: 32'd5};
    tv[1] = '{k: 1, x: 256'd5, y: 256'd7, n: 256'd0, lat: 0, rx: ONES, ry: ONES, cyc: 32'd0};
    tv[2] = '{k: 0, x: 256'hF0, y: 256'h10, n: 256'd2, lat: 1, rx: 256'hF1, ry: 256'h11,
              cyc: 32'd1};
    tv[3] = '{k: 1, x: 256'd5, y: 256'd7, n: 256'd3, lat: 2, rx: 256'd7, ry: 256'd9, cyc: 32'd2};

    i_rst_n = 1'b0;
    i_req = '0;
    i_x = '0;
    i_y = '0;
    i_n = '0;
    i_eng_finished = 1'b0;
    i_eng_result_x = '0;
    i_eng_result_y = '0;
    repeat (2) @(negedge i_clk);

    // Reset values.
    chk("rst_gnt", 256'(o_gnt), 256'd0);
    chk("rst_done", 256'(o_done), 256'd0);
    chk("rst_busy", 256'(o_busy), 256'd0);
    chk("rst_start", 256'(o_eng_start), 256'd0);
    chk("rst_cycles", 256'(o_cycles), 256'd0);
    chk("rst_result_x", o_result_x, ONES);
    chk("rst_result_y", o_result_y, ONES);
    chk("rst_eng_x1", o_eng_x1, 256'd0);
    chk("rst_eng_n", o_eng_n, 256'd0);

    // Both requesting from reset, each released on its grant: requester 0 first.
    set_ops(0, 256'hA0, 256'hB0, 256'd2);
    set_ops(1, 256'hC0, 256'hD0, 256'd5);
    eng_lat = 4;
    sb.push_back(mk_exp(0, 4));
    sb.push_back(mk_exp(1, 4));
    i_req = 2'b11;
    rel_on_gnt = 1'b1;
    gnt_seen = 0;
    d0 = done_cnt;
    i_rst_n = 1'b1;
    wait_idle(100);
    rel_on_gnt = 1'b0;
    chk("sim_grants", 256'(gnt_seen), 256'd2);
    chk("sim_dones", 256'(done_cnt - d0), 256'd2);

    // Single-request vectors.
    for (int j = 0; j < 4; j++) begin
      set_ops(tv[j].k, tv[j].x, tv[j].y, tv[j].n);
      eng_lat = tv[j].lat;
      e.gnt = NREQ'(1 << tv[j].k);
      e.x = tv[j].x;
      e.n = tv[j].n;
      e.rx = tv[j].rx;
      e.ry = tv[j].ry;
      e.cyc = tv[j].cyc;
      sb.push_back(e);
      s0 = start_cnt;
      req_step = step_no;
      i_req = e.gnt;
      step();
      chk("tbl_gnt_t1", 256'(o_gnt), 256'(e.gnt));
      chk("tbl_start_t1", 256'(o_eng_start), 256'(tv[j].n != '0));
      i_req = '0;
      wait_idle(100);
      chk("tbl_latency", 256'(done_step - req_step), 256'(tv[j].lat + 2));
      chk("tbl_starts", 256'(start_cnt - s0), 256'(tv[j].n != '0));
      step();
      chk("tbl_busy_after", 256'(o_busy), 256'd0);
    end

    // Contention: both held for six jobs, grants must alternate starting at 0.
    set_ops(0, 256'h100, 256'h200, 256'd3);
    set_ops(1, 256'h300, 256'h400, 256'd4);
    eng_lat = 3;
    for (int j = 0; j < 6; j++) sb.push_back(mk_exp(j % 2, 3));
    gnt_seen = 0;
    gnt_limit = 6;
    i_req = 2'b11;
    wait_idle(200);
    gnt_limit = 0;
    chk("fair_grants", 256'(gnt_seen), 256'd6);

    // Finish pulse while idle must be ignored.
    step();
    d0 = done_cnt;
    i_eng_finished = 1'b1;
    step();
    step();
    chk("spurious_done", 256'(done_cnt - d0), 256'd0);
    chk("spurious_busy", 256'(o_busy), 256'd0);

    // Saturating cycle counter via a forced near-full count.
    set_ops(0, 256'h11, 256'h22, 256'd5);
    eng_hold = 1'b1;
    eng_lat = 1;
    e = mk_exp(0, 0);
    e.cyc = 32'hFFFF_FFFF;
    sb.push_back(e);
    i_req = 2'b01;
    step();
    i_req = '0;
    step();
    step();
    force dut.cnt_q = 32'hFFFF_FFFF;
    step();
    step();
    release dut.cnt_q;
    step();
    step();
    i_eng_result_x = e.rx;
    i_eng_result_y = e.ry;
    i_eng_finished = 1'b1;
    wait_idle(10);
    eng_hold = 1'b0;

    // Reset in the middle of a job.
    set_ops(0, 256'hABC, 256'hDEF, 256'd7);
    eng_hold = 1'b1;
    eng_lat = 2;
    sb.push_back(mk_exp(0, 2));
    i_req = 2'b01;
    step();
    i_req = '0;
    step();
    step();
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(o_busy), 256'd0);
    chk("mid_rst_cycles", 256'(o_cycles), 256'd0);
    chk("mid_rst_result_x", o_result_x, ONES);
    chk("mid_rst_eng_x1", o_eng_x1, 256'd0);
    chk("mid_rst_gnt_done", 256'({o_gnt, o_done}), 256'd0);
    sb.delete();
    eng_cnt = 0;
    eng_hold = 1'b0;
    i_eng_finished = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    d0 = done_cnt;
    sb.push_back(mk_exp(0, 2));
    req_step = step_no;
    i_req = 2'b01;
    step();
    chk("post_rst_gnt_t1", 256'(o_gnt), 256'd1);
    i_req = '0;
    wait_idle(50);
    chk("post_rst_latency", 256'(done_step - req_step), 256'd4);
    chk("post_rst_dones", 256'(done_cnt - d0), 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
